sopc_buzz_seq: RTL and testbench

SOPC_BUZZ_SEQ -- requirements
Module: sopc_buzz_seq

---
 rtl/sopc_buzz_seq_if.sv | 18 +
 rtl/sopc_buzz_seq.sv | 178 +++++++++++++++++
 tb/tb_sopc_buzz_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sopc_buzz_seq_if.sv
// Avalon-MM slave register bus for the buzzer sequencer.
interface sopc_buzz_seq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sopc_buzz_seq.sv
// Avalon-MM buzzer beep sequencer: ON/OFF periods with optional tone division.
// Define BUZZ_SEQ_IRQ_EN to enable the completion interrupt and CTRL bit2.
module sopc_buzz_seq (
  input  logic             clk,
  input  logic             reset_n,
  sopc_buzz_seq_if.slave   bus,
  output logic             buzz_out,
  output logic             irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t      state_r;
  logic        irq_en_r, done_r, buzz_r, irq_r;
  logic [15:0] tone_div_r, w_tone_r, tone_cnt_r;
  logic [23:0] on_time_r, off_time_r, w_on_r, w_off_r, per_cnt_r;
  logic [7:0]  count_r, w_count_r, remaining_r;

  logic        wr_s, ctrl_wr_s, start_s, stop_s, clr_s, busy_s;
  logic        on_end_s, last_exit_s, done_nxt_s, irq_en_nxt_s;
  logic [23:0] on_last_s;
  logic [31:0] rd_s;
  logic        unused_s;

  assign wr_s      = bus.chipselect & ~bus.write_n;
  assign ctrl_wr_s = wr_s & (bus.address == 3'd0);
  assign start_s   = ctrl_wr_s & bus.writedata[0];
  assign stop_s    = ctrl_wr_s & bus.writedata[1];
  assign clr_s     = wr_s & (bus.address == 3'd5) & bus.writedata[0];
  assign busy_s    = (state_r != ST_IDLE);
  assign unused_s  = ^bus.writedata[31:24];

  // ON_TIME of zero still yields a single ON cycle
  assign on_last_s   = (w_on_r == 24'd0) ? 24'd0 : (w_on_r - 24'd1);
  assign on_end_s    = (state_r == ST_ON) && (per_cnt_r == on_last_s);
  assign last_exit_s = on_end_s && (w_count_r != 8'd0) && (remaining_r == 8'd1) && !stop_s;
  assign done_nxt_s  = last_exit_s | (done_r & ~clr_s);

`ifdef BUZZ_SEQ_IRQ_EN
  assign irq_en_nxt_s = ctrl_wr_s ? bus.writedata[2] : irq_en_r;
`else
  assign irq_en_nxt_s = 1'b0;
`endif

  // Register read mux
  always_comb begin
    rd_s = 32'd0;
    case (bus.address)
      3'd0:    rd_s = {29'd0, irq_en_r, 1'b0, busy_s};
      3'd1:    rd_s = {16'd0, tone_div_r};
      3'd2:    rd_s = {8'd0, on_time_r};
      3'd3:    rd_s = {8'd0, off_time_r};
      3'd4:    rd_s = {24'd0, count_r};
      3'd5:    rd_s = {16'd0, remaining_r, 6'd0, busy_s, done_r};
      default: rd_s = 32'd0;
    endcase
  end

  assign bus.readdata = rd_s;
  assign buzz_out     = buzz_r;
  assign irq          = irq_r;

  // Programmer registers, sequencer FSM and working counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      buzz_r      <= 1'b0;
      irq_r       <= 1'b0;
      done_r      <= 1'b0;
      irq_en_r    <= 1'b0;
      tone_div_r  <= 16'd0;
      on_time_r   <= 24'd0;
      off_time_r  <= 24'd0;
      count_r     <= 8'd1;
      w_tone_r    <= 16'd0;
      w_on_r      <= 24'd0;
      w_off_r     <= 24'd0;
      w_count_r   <= 8'd0;
      remaining_r <= 8'd0;
      per_cnt_r   <= 24'd0;
      tone_cnt_r  <= 16'd0;
    end else begin
      if (wr_s) begin
        case (bus.address)
          3'd1:    tone_div_r <= bus.writedata[15:0];
          3'd2:    on_time_r  <= bus.writedata[23:0];
          3'd3:    off_time_r <= bus.writedata[23:0];
          3'd4:    count_r    <= bus.writedata[7:0];
          default: ;
        endcase
      end else begin
        tone_div_r <= tone_div_r;
      end

      irq_en_r <= irq_en_nxt_s;
      done_r   <= done_nxt_s;
      irq_r    <= done_nxt_s & irq_en_nxt_s;

      if (stop_s) begin
        state_r    <= ST_IDLE;
        buzz_r     <= 1'b0;
        per_cnt_r  <= 24'd0;
        tone_cnt_r <= 16'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            buzz_r <= 1'b0;
            if (start_s) begin
              w_tone_r    <= tone_div_r;
              w_on_r      <= on_time_r;
              w_off_r     <= off_time_r;
              w_count_r   <= count_r;
              remaining_r <= count_r;
              state_r     <= ST_ON;
              buzz_r      <= 1'b1;
              per_cnt_r   <= 24'd0;
              tone_cnt_r  <= 16'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_ON: begin
            if (on_end_s) begin
              per_cnt_r  <= 24'd0;
              tone_cnt_r <= 16'd0;
              if (w_count_r != 8'd0) begin
                remaining_r <= remaining_r - 8'd1;
              end else begin
                remaining_r <= remaining_r;
              end
              if (last_exit_s) begin
                state_r <= ST_IDLE;
                buzz_r  <= 1'b0;
              end else if (w_off_r == 24'd0) begin
                state_r <= ST_ON;
                buzz_r  <= 1'b1;
              end else begin
                state_r <= ST_OFF;
                buzz_r  <= 1'b0;
              end
            end else begin
              per_cnt_r <= per_cnt_r + 24'd1;
              // Tone phase: toggle after every w_tone_r cycles in ON
              if (w_tone_r == 16'd0) begin
                buzz_r <= 1'b1;
              end else if (tone_cnt_r == (w_tone_r - 16'd1)) begin
                buzz_r     <= ~buzz_r;
                tone_cnt_r <= 16'd0;
              end else begin
                tone_cnt_r <= tone_cnt_r + 16'd1;
              end
            end
          end
          ST_OFF: begin
            buzz_r <= 1'b0;
            if (per_cnt_r == (w_off_r - 24'd1)) begin
              state_r    <= ST_ON;
              buzz_r     <= 1'b1;
              per_cnt_r  <= 24'd0;
              tone_cnt_r <= 16'd0;
            end else begin
              per_cnt_r <= per_cnt_r + 24'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            buzz_r  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sopc_buzz_seq.sv
// Directed bench for sopc_buzz_seq; buzz_out is scored against a queue of expected bits.
module tb_sopc_buzz_seq;

`ifdef BUZZ_SEQ_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic buzz_out;
  logic irq;
  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];
  logic mon_e;

  sopc_buzz_seq_if bus ();

  sopc_buzz_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .buzz_out (buzz_out),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: one expected buzz bit consumed per cycle while outstanding
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("buzz_seq", {31'd0, buzz_out}, {31'd0, mon_e});
    end
  end

  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i] == 8'h31);
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.write_n    = 1'b1;
    bus.chipselect = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, input logic [31:0] exp_v, input string tag);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    chk(tag, bus.readdata, exp_v);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk("rst_buzz", {31'd0, buzz_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    read_reg(3'd0, 32'd0, "rst_ctrl");
    read_reg(3'd1, 32'd0, "rst_tone");
    read_reg(3'd2, 32'd0, "rst_on");
    read_reg(3'd3, 32'd0, "rst_off");
    read_reg(3'd4, 32'd1, "rst_count");
    read_reg(3'd5, 32'd0, "rst_status");

    // Two plain beeps with a gap
    write_reg(3'd1, 32'd0);
    write_reg(3'd2, 32'd4);
    write_reg(3'd3, 32'd3);
    write_reg(3'd4, 32'd2);
    write_reg(3'd0, 32'h1);
    push_bits("11110001111");
    wait_drain();
    chk("t030_buzz_end", {31'd0, buzz_out}, 32'd0);
    read_reg(3'd5, 32'h1, "t030_status_done");
    read_reg(3'd0, 32'h0, "t030_ctrl_idle");

    // Tone-divided single beep
    write_reg(3'd5, 32'h1);
    read_reg(3'd5, 32'h0, "t031_done_clr");
    write_reg(3'd1, 32'd2);
    write_reg(3'd2, 32'd8);
    write_reg(3'd4, 32'd1);
    write_reg(3'd0, 32'h1);
    push_bits("11001100");
    read_reg(3'd5, 32'h102, "t031_status_busy");
    read_reg(3'd0, 32'h1, "t031_ctrl_busy");
    wait_drain();
    chk("t031_buzz_end", {31'd0, buzz_out}, 32'd0);
    read_reg(3'd5, 32'h1, "t031_status_done");

    // Endless repeat, then STOP; then STOP+START together from idle
    write_reg(3'd5, 32'h1);
    write_reg(3'd4, 32'd0);
    write_reg(3'd2, 32'd5);
    write_reg(3'd3, 32'd5);
    write_reg(3'd1, 32'd0);
    write_reg(3'd0, 32'h1);
    push_bits("11111000001111100000111");
    repeat (22) @(posedge clk);
    #1;
    write_reg(3'd0, 32'h2);
    wait_drain();
    chk("t032_buzz_stop", {31'd0, buzz_out}, 32'd0);
    read_reg(3'd5, 32'h0, "t032_status_stop");
    write_reg(3'd0, 32'h3);
    chk("t032_stopstart_buzz", {31'd0, buzz_out}, 32'd0);
    read_reg(3'd0, 32'h0, "t032_stopstart_ctrl");

    // Config writes and START while busy do not disturb the running beep
    write_reg(3'd4, 32'd1);
    write_reg(3'd2, 32'd6);
    write_reg(3'd3, 32'd0);
    write_reg(3'd1, 32'd0);
    write_reg(3'd0, 32'h1);
    push_bits("111111");
    write_reg(3'd2, 32'd2);
    write_reg(3'd1, 32'd1);
    write_reg(3'd0, 32'h1);
    wait_drain();
    chk("t033_buzz_end", {31'd0, buzz_out}, 32'd0);
    read_reg(3'd2, 32'd2, "t033_on_visible");
    read_reg(3'd1, 32'd1, "t033_tone_visible");
    read_reg(3'd5, 32'h1, "t033_status_done");
    write_reg(3'd5, 32'h1);
    write_reg(3'd0, 32'h1);
    push_bits("10");
    wait_drain();
    chk("t033_buzz_end2", {31'd0, buzz_out}, 32'd0);
    read_reg(3'd5, 32'h1, "t033_status_done2");

    // Interrupt on completion, clear, and clear coincident with completion
    write_reg(3'd5, 32'h1);
    write_reg(3'd1, 32'd0);
    write_reg(3'd0, 32'h4);
    read_reg(3'd0, IRQ_BUILD ? 32'h4 : 32'h0, "t034_ctrl_irqen");
    write_reg(3'd0, 32'h5);
    push_bits("11");
    wait_drain();
    chk("t034_irq_set", {31'd0, irq}, {31'd0, IRQ_BUILD});
    chk("t034_buzz_end", {31'd0, buzz_out}, 32'd0);
    read_reg(3'd5, 32'h1, "t034_status_done");
    write_reg(3'd5, 32'h1);
    chk("t034_irq_clr", {31'd0, irq}, 32'd0);
    read_reg(3'd5, 32'h0, "t034_status_clr");
    write_reg(3'd0, 32'h5);
    push_bits("11");
    @(posedge clk);
    #1;
    write_reg(3'd5, 32'h1);
    chk("t034_irq_setwins", {31'd0, irq}, {31'd0, IRQ_BUILD});
    read_reg(3'd5, 32'h1, "t034_done_setwins");
    read_reg(3'd6, 32'h0, "unmapped_6");
    read_reg(3'd7, 32'h0, "unmapped_7");

    // Reset in the middle of an ON period
    write_reg(3'd1, 32'd3);
    write_reg(3'd2, 32'd10);
    write_reg(3'd3, 32'd2);
    write_reg(3'd4, 32'd3);
    write_reg(3'd0, 32'h5);
    push_bits("111");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_drain();
    chk("t035_buzz", {31'd0, buzz_out}, 32'd0);
    chk("t035_irq", {31'd0, irq}, 32'd0);
    read_reg(3'd0, 32'h0, "t035_ctrl");
    read_reg(3'd1, 32'h0, "t035_tone");
    read_reg(3'd2, 32'h0, "t035_on");
    read_reg(3'd3, 32'h0, "t035_off");
    read_reg(3'd4, 32'h1, "t035_count");
    read_reg(3'd5, 32'h0, "t035_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
